axis_frame_gen: RTL and testbench

AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

---
 rtl/axis_frame_gen.sv | 197 +++++++++++++++++++
 tb/tb_axis_frame_gen.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_gen
// Description : AXI4-Stream frame generator emitting an incrementing byte
//               pattern. Define AXIS_FRAME_GEN_THROTTLE_EN for LFSR gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_gen #(
    parameter int TDATA_BYTES = 4,
    parameter int TID_WIDTH   = 4,
    parameter int TDEST_WIDTH = 4,
    parameter int TUSER_WIDTH = 1,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     start,
    input  logic [LEN_WIDTH-1:0]     frame_bytes,
    input  logic [7:0]               seed,
    input  logic [TID_WIDTH-1:0]     cfg_id,
    input  logic [TDEST_WIDTH-1:0]   cfg_dest,
    output logic                     TVALID,
    input  logic                     TREADY,
    output logic [8*TDATA_BYTES-1:0] TDATA,
    output logic [TDATA_BYTES-1:0]   TSTRB,
    output logic [TDATA_BYTES-1:0]   TKEEP,
    output logic                     TLAST,
    output logic [TID_WIDTH-1:0]     TID,
    output logic [TDEST_WIDTH-1:0]   TDEST,
    output logic [TUSER_WIDTH-1:0]   TUSER,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              frame_count
);

    localparam int c_DATA_W = 8 * TDATA_BYTES;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                   r_state,       w_state;
    logic [LEN_WIDTH-1:0]     r_remaining,   w_remaining;
    logic [7:0]               r_base,        w_base;
    logic                     r_tvalid,      w_tvalid;
    logic [c_DATA_W-1:0]      r_tdata,       w_tdata;
    logic [TDATA_BYTES-1:0]   r_tkeep,       w_tkeep;
    logic                     r_tlast,       w_tlast;
    logic [TID_WIDTH-1:0]     r_tid,         w_tid;
    logic [TDEST_WIDTH-1:0]   r_tdest,       w_tdest;
    logic                     r_done,        w_done;
    logic [31:0]              r_frame_count, w_frame_count;

    logic                     w_hs;
    logic                     w_gap;
    logic [LEN_WIDTH-1:0]     w_rem_next;
    logic [7:0]               w_base_next;

    // Bytes at or beyond the remaining count are zeroed so partial beats are clean.
    function automatic logic [c_DATA_W-1:0] beat_data(input logic [7:0] base,
                                                      input logic [LEN_WIDTH-1:0] rem);
        logic [c_DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < TDATA_BYTES; i++) begin
            if (32'(rem) > 32'(i)) d[8*i +: 8] = base + 8'(i);
        end
        return d;
    endfunction

    function automatic logic [TDATA_BYTES-1:0] beat_keep(input logic [LEN_WIDTH-1:0] rem);
        logic [TDATA_BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < TDATA_BYTES; i++) begin
            k[i] = (32'(rem) > 32'(i));
        end
        return k;
    endfunction

`ifdef AXIS_FRAME_GEN_THROTTLE_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        end
    end

    assign w_gap = r_lfsr[0];
`else
    assign w_gap = 1'b0;
`endif

    assign w_hs        = r_tvalid & TREADY;
    // Only consumed when more than one beat remains, so the subtraction cannot wrap.
    assign w_rem_next  = r_remaining - LEN_WIDTH'(TDATA_BYTES);
    assign w_base_next = r_base + 8'(TDATA_BYTES);

    always_comb begin
        w_state       = r_state;
        w_remaining   = r_remaining;
        w_base        = r_base;
        w_tvalid      = r_tvalid;
        w_tdata       = r_tdata;
        w_tkeep       = r_tkeep;
        w_tlast       = r_tlast;
        w_tid         = r_tid;
        w_tdest       = r_tdest;
        w_done        = 1'b0;
        w_frame_count = r_frame_count;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_tid   = cfg_id;
                    w_tdest = cfg_dest;
                    if (frame_bytes == '0) begin
                        w_done = 1'b1;
                    end else begin
                        w_state     = ST_SEND;
                        w_remaining = frame_bytes;
                        w_base      = seed;
                        w_tvalid    = 1'b1;
                        w_tdata     = beat_data(seed, frame_bytes);
                        w_tkeep     = beat_keep(frame_bytes);
                        w_tlast     = (32'(frame_bytes) <= 32'(TDATA_BYTES));
                    end
                end
            end
            ST_SEND: begin
                if (w_hs) begin
                    if (r_tlast) begin
                        w_state       = ST_IDLE;
                        w_tvalid      = 1'b0;
                        w_tlast       = 1'b0;
                        w_done        = 1'b1;
                        w_frame_count = r_frame_count + 32'd1;
                    end else begin
                        w_remaining = w_rem_next;
                        w_base      = w_base_next;
                        w_tvalid    = ~w_gap;
                        w_tdata     = beat_data(w_base_next, w_rem_next);
                        w_tkeep     = beat_keep(w_rem_next);
                        w_tlast     = (32'(w_rem_next) <= 32'(TDATA_BYTES));
                    end
                end else if (!r_tvalid) begin
                    w_tvalid = 1'b1;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state       <= ST_IDLE;
            r_remaining   <= '0;
            r_base        <= '0;
            r_tvalid      <= 1'b0;
            r_tdata       <= '0;
            r_tkeep       <= '0;
            r_tlast       <= 1'b0;
            r_tid         <= '0;
            r_tdest       <= '0;
            r_done        <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state;
            r_remaining   <= w_remaining;
            r_base        <= w_base;
            r_tvalid      <= w_tvalid;
            r_tdata       <= w_tdata;
            r_tkeep       <= w_tkeep;
            r_tlast       <= w_tlast;
            r_tid         <= w_tid;
            r_tdest       <= w_tdest;
            r_done        <= w_done;
            r_frame_count <= w_frame_count;
        end
    end

    assign TVALID      = r_tvalid;
    assign TDATA       = r_tdata;
    assign TKEEP       = r_tkeep;
    assign TSTRB       = r_tkeep;
    assign TLAST       = r_tlast;
    assign TID         = r_tid;
    assign TDEST       = r_tdest;
    assign TUSER       = '0;
    assign busy        = (r_state == ST_SEND);
    assign done        = r_done;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_frame_gen
// Description : Scoreboard bench for axis_frame_gen with a byte-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_gen;

    localparam int B = 4;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        start;
    logic [15:0] frame_bytes;
    logic [7:0]  seed;
    logic [3:0]  cfg_id;
    logic [3:0]  cfg_dest;
    logic        TVALID;
    logic        TREADY;
    logic [31:0] TDATA;
    logic [3:0]  TSTRB;
    logic [3:0]  TKEEP;
    logic        TLAST;
    logic [3:0]  TID;
    logic [3:0]  TDEST;
    logic [0:0]  TUSER;
    logic        busy;
    logic        done;
    logic [31:0] frame_count;

    axis_frame_gen dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .start       (start),
        .frame_bytes (frame_bytes),
        .seed        (seed),
        .cfg_id      (cfg_id),
        .cfg_dest    (cfg_dest),
        .TVALID      (TVALID),
        .TREADY      (TREADY),
        .TDATA       (TDATA),
        .TSTRB       (TSTRB),
        .TKEEP       (TKEEP),
        .TLAST       (TLAST),
        .TID         (TID),
        .TDEST       (TDEST),
        .TUSER       (TUSER),
        .busy        (busy),
        .done        (done),
        .frame_count (frame_count)
    );

    initial forever #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [3:0]  id;
        logic [3:0]  dest;
    } beat_t;

    beat_t sb[$];
    int    n_checks  = 0;
    int    n_pass    = 0;
    int    hs_cnt    = 0;
    int    done_cnt  = 0;
    int    done_exp  = 0;
    int    fc_exp    = 0;
    int    rdy_mode  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got timeout, required event within budget", name);
    endtask

    // Reference: byte j of the frame is (seed + j) mod 256, valid only when j < n.
    task automatic push_frame(input int n, input int sd, input logic [3:0] id, input logic [3:0] dest);
        int beats;
        beats = (n + B - 1) / B;
        for (int k = 0; k < beats; k++) begin
            beat_t b;
            b.data = '0;
            b.keep = '0;
            for (int i = 0; i < B; i++) begin
                int j;
                j = k * B + i;
                if (j < n) begin
                    b.data[8*i +: 8] = 8'((sd + j) % 256);
                    b.keep[i] = 1'b1;
                end
            end
            b.last = (k == beats - 1);
            b.id   = id;
            b.dest = dest;
            sb.push_back(b);
        end
    endtask

    task automatic send(input int n, input int sd, input logic [3:0] id, input logic [3:0] dest);
        start       = 1'b1;
        frame_bytes = 16'(n);
        seed        = 8'(sd);
        cfg_id      = id;
        cfg_dest    = dest;
        if (n > 0) begin
            push_frame(n, sd, id, dest);
            fc_exp++;
        end
        done_exp++;
        @(posedge ACLK);
        #1 start = 1'b0;
    endtask

    task automatic wait_not_busy(input int budget);
        int t;
        t = 0;
        @(negedge ACLK);
        while (busy && t < budget) begin
            @(negedge ACLK);
            t++;
        end
        if (busy) fail_now("wait_not_busy");
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        @(negedge ACLK);
        while ((busy || sb.size() != 0) && t < budget) begin
            @(negedge ACLK);
            t++;
        end
        if (busy || sb.size() != 0) fail_now("wait_idle");
    endtask

    initial begin
        TREADY = 1'b1;
        forever begin
            @(posedge ACLK);
            #1;
            case (rdy_mode)
                0:       TREADY = 1'b1;
                1:       TREADY = ($urandom % 4) != 0;
                default: TREADY = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    initial begin
        logic        pend;
        logic        b2b;
        logic [63:0] held;
        beat_t       e;
        pend = 1'b0;
        b2b  = 1'b0;
        held = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                pend = 1'b0;
                b2b  = 1'b0;
            end else begin
                if (pend) begin
                    check("hold_tvalid", 64'(TVALID), 64'd1);
                    check("hold_payload", 64'({TDATA, TKEEP, TSTRB, TLAST, TID, TDEST}), held);
                end
`ifndef AXIS_FRAME_GEN_THROTTLE_EN
                if (b2b) check("back_to_back", 64'(TVALID), 64'd1);
`endif
                pend = 1'b0;
                b2b  = 1'b0;
                if (TVALID && TREADY) begin
                    hs_cnt++;
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got beat 0x%0h, required none", TDATA);
                    end else begin
                        e = sb.pop_front();
                        check("beat", 64'({TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER}),
                              64'({e.data, e.keep, e.keep, e.last, e.id, e.dest, 1'b0}));
                    end
                    b2b = !TLAST;
                end else if (TVALID) begin
                    pend = 1'b1;
                    held = 64'({TDATA, TKEEP, TSTRB, TLAST, TID, TDEST});
                end
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, required end of test");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int t;
        ARESETn     = 1'b0;
        start       = 1'b0;
        frame_bytes = '0;
        seed        = '0;
        cfg_id      = '0;
        cfg_dest    = '0;

        // Reset state
        repeat (3) @(negedge ACLK);
        check("rst_ctrl", 64'({TVALID, TLAST, done, busy}), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_payload", 64'({TDATA, TKEEP, TSTRB, TID, TDEST, TUSER}), 64'd0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("post_reset_tvalid", 64'(TVALID), 64'd0);

        // Reference frame: seed 0x10, 10 bytes
        send(10, 'h10, 4'h3, 4'h5);
        wait_idle(100);
        check("frame_count_1", 64'(frame_count), 64'd1);

        // Zero-length frame
        send(0, 'h22, 4'h1, 4'h2);
        @(negedge ACLK);
        check("zero_len_done", 64'(done), 64'd1);
        check("zero_len_tvalid", 64'(TVALID), 64'd0);
        check("zero_len_count", 64'(frame_count), 64'(fc_exp));

        // Start accepted in the done cycle
        send(6, 'h30, 4'h7, 4'h8);
        t = 0;
        @(negedge ACLK);
        while (!done && t < 50) begin
            @(negedge ACLK);
            t++;
        end
        if (!done) fail_now("wait_done");
        send(4, 'h80, 4'h9, 4'hA);
        @(negedge ACLK);
        check("start_on_done_busy", 64'(busy), 64'd1);
        wait_idle(100);

        // Stall: TREADY low while beat 0 is presented
        rdy_mode = 2;
        repeat (2) @(negedge ACLK);
        hs0 = hs_cnt;
        send(8, 'h40, 4'h2, 4'h4);
        t = 0;
        @(negedge ACLK);
        while (!TVALID && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        if (!TVALID) fail_now("wait_tvalid");
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge ACLK);
            check("stall_tvalid", 64'(TVALID), 64'd1);
            check("stall_tdata", 64'(TDATA), 64'h43424140);
        end
        rdy_mode = 0;
        wait_idle(100);
        check("stall_handshakes", 64'(hs_cnt - hs0), 64'd2);

        // start pulsed mid-frame is ignored
        rdy_mode = 1;
        wait_not_busy(200);
        send(20, 'h55, 4'hB, 4'hC);
        repeat (2) @(negedge ACLK);
        check("busy_mid_frame", 64'(busy), 64'd1);
        start       = 1'b1;
        frame_bytes = 16'd3;
        seed        = 8'hEE;
        @(posedge ACLK);
        #1 start = 1'b0;
        wait_idle(400);
        check("ignore_start_count", 64'(frame_count), 64'(fc_exp));

        // Reset after beat 1 of a 5-beat frame
        rdy_mode = 0;
        wait_not_busy(200);
        hs0 = hs_cnt;
        send(20, 'h60, 4'h5, 4'h6);
        t = 0;
        while (hs_cnt < hs0 + 2 && t < 50) begin
            @(negedge ACLK);
            t++;
        end
        if (hs_cnt < hs0 + 2) fail_now("wait_beat1");
        @(posedge ACLK);
        #1 ARESETn = 1'b0;
        sb.delete();
        fc_exp   = 0;
        done_exp = done_exp - 1;
        @(negedge ACLK);
        check("midreset_ctrl", 64'({TVALID, busy, done}), 64'd0);
        check("midreset_count", 64'(frame_count), 64'd0);
        ARESETn = 1'b1;
        repeat (3) @(negedge ACLK);
        check("midreset_no_done", 64'(done_cnt), 64'(done_exp));
        send(20, 'h61, 4'h5, 4'h6);
        wait_idle(100);
        check("after_reset_count", 64'(frame_count), 64'd1);

        // Randomized frames with random back-pressure
        rdy_mode = 1;
        for (int f = 0; f < 25; f++) begin
            wait_not_busy(400);
            send(int'($urandom_range(0, 40)), int'($urandom_range(0, 255)),
                 4'($urandom), 4'($urandom));
        end
        wait_idle(1000);
        check("random_count", 64'(frame_count), 64'(fc_exp));

        // Largest frame length
        rdy_mode = 0;
        wait_not_busy(100);
        send(65535, 'hA5, 4'hF, 4'h1);
        wait_idle(20000);
        check("max_len_count", 64'(frame_count), 64'(fc_exp));
        check("done_pulses", 64'(done_cnt), 64'(done_exp));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
